// File: rtl/scam_multi_blocking_writer_pkg.sv
// Shared types for the multi-channel blocking writer.
// Sections:
//   SEC_RR   - round-robin, one channel per transaction
//   SEC_BC   - broadcast, all channels carry the same word
//   SEC_IDLE - halted, no channel offers data
package scam_multi_writer_types;

  typedef enum logic [1:0] {
    SEC_RR   = 2'd0,
    SEC_BC   = 2'd1,
    SEC_IDLE = 2'd2
  } Sections;

endpackage

// File: rtl/scam_bw_channel.sv
// One output channel of the blocking writer: holds the data word and the notify flag.
// Ports:
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   load_i    - start a new offer with value_i (wins over a same-cycle transfer)
//   value_i   - word to offer
//   sync_i    - consumer ready
//   data_o    - offered word, stable while notify_o is high
//   notify_o  - offer valid
//   done_o    - transfer happens this cycle (notify_o && sync_i)
module scam_bw_channel #(
  parameter int unsigned       DataW     = 32,
  parameter bit                RstNotify = 1'b0,
  parameter logic [DataW-1:0]  RstData   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DataW-1:0] value_i,
  input  logic             sync_i,
  output logic [DataW-1:0] data_o,
  output logic             notify_o,
  output logic             done_o
);

  logic [DataW-1:0] data_d, data_q;
  logic             notify_d, notify_q;

  assign done_o   = notify_q & sync_i;
  assign data_o   = data_q;
  assign notify_o = notify_q;

  always_comb begin
    data_d   = data_q;
    notify_d = notify_q;
    if (load_i) begin
      data_d   = value_i;
      notify_d = 1'b1;
    end else if (done_o) begin
      notify_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= RstData;
      notify_q <= RstNotify;
    end else begin
      data_q   <= data_d;
      notify_q <= notify_d;
    end
  end

endmodule

// File: rtl/scam_multi_blocking_writer.sv
// Blocking-write master driving NUM_CH notify/sync channels with a counter value,
// either round-robin (one channel per transaction) or broadcast (all channels).
// Ports:
//   clk, rst    - clock (rising edge), asynchronous active-high reset
//   mode_bcast  - 1 = broadcast, 0 = round-robin; sampled at a transaction boundary
//   halt        - go idle; sampled at a transaction boundary
//   out_data    - channel i word at [i*DATA_W +: DATA_W]
//   out_sync    - per-channel consumer ready
//   out_notify  - per-channel data valid
//   section     - current section
//   sent_count  - completed transactions, wraps
module scam_multi_blocking_writer
  import scam_multi_writer_types::*;
#(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        NUM_CH    = 4,
  parameter logic [DATA_W-1:0]  START_VAL = '0,
  parameter logic [DATA_W-1:0]  STEP      = DATA_W'(1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode_bcast,
  input  logic                     halt,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic [NUM_CH-1:0]        out_sync,
  output logic [NUM_CH-1:0]        out_notify,
  output Sections                  section,
  output logic [31:0]              sent_count
);

  localparam int unsigned     PtrW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NUM_CH - 1);

  Sections           section_d, section_q;
  logic [PtrW-1:0]   ptr_d, ptr_q;
  logic [DATA_W-1:0] cnt_d, cnt_q;
  logic [NUM_CH-1:0] mask_d, mask_q;
  logic [31:0]       sent_d, sent_q;

  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] load;
  logic              completed;
  logic              boundary;

  always_comb begin
    section_d = section_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    sent_d    = sent_q;
    load      = '0;
    completed = 1'b0;
    boundary  = 1'b0;

    unique case (section_q)
      SEC_RR: begin
        if (done[ptr_q]) begin
          completed = 1'b1;
          ptr_d     = (ptr_q == LastPtr) ? '0 : ptr_q + 1'b1;
        end
      end
      SEC_BC: begin
        // Several channels may finish in the same cycle; the last one closes the transaction.
        mask_d = mask_q & ~done;
        if (mask_d == '0) completed = 1'b1;
      end
      SEC_IDLE: boundary = ~halt;
      default: ;
    endcase

    if (completed) begin
      cnt_d    = cnt_q + STEP;
      sent_d   = sent_q + 32'd1;
      boundary = 1'b1;
    end

    // Next transaction starts the very next cycle; channels reload with the updated count.
    if (boundary) begin
      if (halt) begin
        section_d = SEC_IDLE;
        mask_d    = '0;
      end else if (mode_bcast) begin
        section_d = SEC_BC;
        mask_d    = '1;
        load      = '1;
      end else begin
        section_d    = SEC_RR;
        mask_d       = '0;
        load[ptr_d]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section_q <= SEC_RR;
      ptr_q     <= '0;
      cnt_q     <= START_VAL;
      mask_q    <= '0;
      sent_q    <= '0;
    end else begin
      section_q <= section_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      sent_q    <= sent_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    scam_bw_channel #(
      .DataW     (DATA_W),
      .RstNotify (i == 0),
      .RstData   ((i == 0) ? START_VAL : '0)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load[i]),
      .value_i  (cnt_d),
      .sync_i   (out_sync[i]),
      .data_o   (out_data[i*DATA_W +: DATA_W]),
      .notify_o (out_notify[i]),
      .done_o   (done[i])
    );
  end

  assign section    = section_q;
  assign sent_count = sent_q;

endmodule
